// File: rtl/rv64g_l1_vlsu_gather_pkg.sv
// Shared constants, FSM encoding and helpers for the L1 vector gather initiator.
package rv64g_l1_vlsu_gather_pkg;

  localparam int XLEN       = 64;
  localparam int NUM_LANES  = 8;
  localparam int NUM_BANKS  = 8;
  localparam int TAG_W      = 53;
  localparam int WAY_W      = 3;
  localparam int ELEM_BYTES = 8;
  localparam int LANE_IDX_W = $clog2(NUM_LANES);
  localparam int BANK_IDX_W = $clog2(NUM_BANKS);
  localparam int BANK_LSB   = $clog2(ELEM_BYTES);
  localparam int BANK_MSB   = BANK_LSB + BANK_IDX_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_RESP
  } state_e;

  function automatic logic [BANK_IDX_W-1:0] bank_of(input logic [XLEN-1:0] addr);
    return addr[BANK_MSB:BANK_LSB];
  endfunction

  // Element counts above NUM_LANES saturate to a full mask.
  function automatic logic [NUM_LANES-1:0] vl_to_mask(input logic [3:0] vl);
    logic [NUM_LANES-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (k < int'(vl)) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rv64g_vlsu_addr_gen.sv
// Combinational strided address generator: lane k gets base + k*stride (mod 2^64).
module rv64g_vlsu_addr_gen
  import rv64g_l1_vlsu_gather_pkg::*;
(
  input  logic [XLEN-1:0]           base,
  input  logic [XLEN-1:0]           stride,
  output logic [NUM_LANES*XLEN-1:0] addr
);

  always_comb begin
    addr = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      addr[k*XLEN +: XLEN] = base + stride * XLEN'(k);
    end
  end

endmodule

// File: rtl/rv64g_l1_vlsu_gather.sv
// Vector port (Port B) initiator: issues one strided op, gathers per-lane read data, returns one response.
// Optional macro VLSU_SRCLANE_CHECK_EN adds a sticky srclane_err_o bank-ownership check.
module rv64g_l1_vlsu_gather
  import rv64g_l1_vlsu_gather_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_we_i,
  input  logic [XLEN-1:0]                 req_base_i,
  input  logic [XLEN-1:0]                 req_stride_i,
  input  logic [3:0]                      req_vl_i,
  input  logic [NUM_LANES*WAY_W-1:0]      req_way_i,
  input  logic [NUM_LANES*XLEN-1:0]       req_wdata_i,
  input  logic [NUM_LANES*8-1:0]          req_be_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic                            resp_we_o,
  output logic [NUM_LANES-1:0]            resp_mask_o,
  output logic [NUM_LANES*XLEN-1:0]       resp_rdata_o,
  output logic                            vlsu_req_o,
  output logic [NUM_LANES-1:0]            vlsu_lane_valid_o,
  output logic [NUM_LANES-1:0]            vlsu_lane_we_o,
  output logic [NUM_LANES*XLEN-1:0]       vlsu_lane_addr_o,
  output logic [NUM_LANES*XLEN-1:0]       vlsu_lane_wdata_o,
  output logic [NUM_LANES*8-1:0]          vlsu_lane_be_o,
  output logic [NUM_LANES*WAY_W-1:0]      vlsu_lane_way_o,
  output logic [NUM_LANES*TAG_W-1:0]      vlsu_lane_tag_o,
  output logic [NUM_LANES*2-1:0]          vlsu_lane_state_o,
  input  logic                            vlsu_ready_i,
  input  logic                            vlsu_done_i,
  input  logic [NUM_LANES-1:0]            vlsu_lane_done_i,
  input  logic [NUM_BANKS*XLEN-1:0]       vec_bank_rdata_i,
  input  logic [NUM_BANKS*LANE_IDX_W-1:0] vec_bank_src_lane_i,
`ifdef VLSU_SRCLANE_CHECK_EN
  output logic                            srclane_err_o,
`endif
  output logic [15:0]                     stall_cycles_o
);

  state_e                      state, state_next;
  logic                        we_r;
  logic [NUM_LANES-1:0]        active_r, done_r, pend_r;
  logic [NUM_LANES*XLEN-1:0]   addr_r, wdata_r, rdata_r;
  logic [NUM_LANES*8-1:0]      be_r;
  logic [NUM_LANES*WAY_W-1:0]  way_r;
  logic [15:0]                 stall_r;
  logic [NUM_LANES*XLEN-1:0]   gen_addr;
  logic [XLEN-1:0]             bank_rdata [NUM_BANKS];
  logic                        accept, issue, all_done;
  logic [NUM_LANES-1:0]        lane_valid, newly;
  logic                        unused_ok;

  rv64g_vlsu_addr_gen u_addr_gen (
    .base   (req_base_i),
    .stride (req_stride_i),
    .addr   (gen_addr)
  );

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_rdata[b] = vec_bank_rdata_i[b*XLEN +: XLEN];
    end
  end

  assign accept     = (state == ST_IDLE) && req_valid_i;
  assign issue      = (state == ST_ISSUE);
  assign lane_valid = issue ? (active_r & ~done_r) : '0;
  assign newly      = vlsu_lane_done_i & lane_valid;
  assign all_done   = ((done_r | newly) == active_r) || vlsu_done_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // An empty op (vl=0) has no grant to capture, so it skips DRAIN even for loads.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (req_valid_i) state_next = ST_ISSUE;
      ST_ISSUE: if (all_done) state_next = (!we_r && active_r != '0) ? ST_DRAIN : ST_RESP;
      ST_DRAIN: state_next = ST_RESP;
      ST_RESP:  if (resp_ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_r     <= 1'b0;
      active_r <= '0;
      done_r   <= '0;
      pend_r   <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rdata_r  <= '0;
      be_r     <= '0;
      way_r    <= '0;
      stall_r  <= '0;
    end else begin
      pend_r <= '0;
      if (accept) begin
        we_r     <= req_we_i;
        active_r <= vl_to_mask(req_vl_i);
        done_r   <= '0;
        addr_r   <= gen_addr;
        wdata_r  <= req_wdata_i;
        be_r     <= req_be_i;
        way_r    <= req_way_i;
        rdata_r  <= '0;
      end
      if (issue) begin
        done_r <= done_r | newly;
        if (!we_r) pend_r <= newly;
        if (|(lane_valid & ~vlsu_lane_done_i) && stall_r != 16'hFFFF) stall_r <= stall_r + 16'd1;
      end
      // Read data lags its grant by one cycle; the bank is re-derived from the lane address.
      for (int k = 0; k < NUM_LANES; k++) begin
        if (pend_r[k]) rdata_r[k*XLEN +: XLEN] <= bank_rdata[bank_of(addr_r[k*XLEN +: XLEN])];
      end
    end
  end

`ifdef VLSU_SRCLANE_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      srclane_err_o <= 1'b0;
    end else if (issue) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (newly[k] &&
            vec_bank_src_lane_i[int'(bank_of(addr_r[k*XLEN +: XLEN]))*LANE_IDX_W +: LANE_IDX_W]
              != LANE_IDX_W'(k))
          srclane_err_o <= 1'b1;
      end
    end
  end
  assign unused_ok = vlsu_ready_i;
`else
  assign unused_ok = ^{vlsu_ready_i, vec_bank_src_lane_i};
`endif

  assign req_ready_o       = (state == ST_IDLE);
  assign vlsu_req_o        = issue && (active_r != '0);
  assign vlsu_lane_valid_o = lane_valid;
  assign vlsu_lane_we_o    = lane_valid & {NUM_LANES{we_r}};
  assign vlsu_lane_addr_o  = vlsu_req_o ? addr_r  : '0;
  assign vlsu_lane_wdata_o = vlsu_req_o ? wdata_r : '0;
  assign vlsu_lane_be_o    = vlsu_req_o ? be_r    : '0;
  assign vlsu_lane_way_o   = vlsu_req_o ? way_r   : '0;
  assign vlsu_lane_tag_o   = '0;
  assign vlsu_lane_state_o = '0;
  assign resp_valid_o      = (state == ST_RESP);
  assign resp_we_o         = resp_valid_o & we_r;
  assign resp_mask_o       = resp_valid_o ? active_r : '0;
  assign resp_rdata_o      = resp_valid_o ? rdata_r  : '0;
  assign stall_cycles_o    = stall_r;

endmodule
